// File: rtl/micro_seq_ctrl.sv
// Micro-program sequencer: dispatches a bytecode opcode to a micro-address,
// then walks a writable next-address table until the terminator entry.
module micro_seq_ctrl #(
   parameter int unsigned ADR_W         = 9,
   parameter int unsigned OP_W          = 8,
   parameter int unsigned DISPATCH_BASE = 0,
   parameter int unsigned END_ADR       = 0,
   parameter int unsigned MAX_STEPS     = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             cfg_we,
   input  logic [ADR_W-1:0] cfg_adr,
   input  logic [ADR_W-1:0] cfg_data,
   output logic             cfg_ready,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [OP_W-1:0]  opcode,
   output logic             uop_valid,
   input  logic             uop_ready,
   output logic [ADR_W-1:0] uop_adr,
   output logic             uop_last,
   output logic             busy,
   output logic             init_done,
   output logic             err
);

   localparam int unsigned DEPTH  = 1 << ADR_W;
   localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN} state_e;

   state_e              state_q, state_d;
   logic [ADR_W-1:0]    clr_q, clr_d;
   logic [ADR_W-1:0]    adr_q, adr_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                err_q, err_d;
   logic                init_done_q, init_done_d;

   logic [ADR_W-1:0]    tbl_q [DEPTH];
   logic [ADR_W-1:0]    tbl_rd;
   logic                tbl_we;
   logic [ADR_W-1:0]    tbl_wadr;
   logic [ADR_W-1:0]    tbl_wdata;
   logic                last_c;
   logic                b2b_c;
   logic [ADR_W-1:0]    disp_adr;

   // Asynchronous table read and derived handshake terms.
   assign tbl_rd   = tbl_q[adr_q];
   assign last_c   = (tbl_rd == ADR_W'(END_ADR));
   assign disp_adr = ADR_W'(DISPATCH_BASE) + ADR_W'(opcode);
   assign b2b_c    = (state_q == S_RUN) && uop_ready && last_c && op_valid;

   assign cfg_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign uop_valid = (state_q == S_RUN);
   assign uop_last  = (state_q == S_RUN) && last_c;
   assign op_ready  = !flush && ((state_q == S_IDLE) || b2b_c);
   assign uop_adr   = adr_q;
   assign init_done = init_done_q;
   assign err       = err_q;

   // Table write port: INIT clear sweep has priority, cfg writes only in IDLE.
   assign tbl_we    = (state_q == S_INIT) || (cfg_we && cfg_ready);
   assign tbl_wadr  = (state_q == S_INIT) ? clr_q : cfg_adr;
   assign tbl_wdata = (state_q == S_INIT) ? ADR_W'(END_ADR) : cfg_data;

   // Table storage; contents are established by the INIT sweep, not by reset.
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         tbl_q[tbl_wadr] <= tbl_wdata;
      end
   end

   // Next-state logic: clear sweep, dispatch, table walk and runaway guard.
   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      adr_d       = adr_q;
      step_d      = step_q;
      err_d       = err_q;
      init_done_d = init_done_q;
      case (state_q)
         S_INIT: begin
            clr_d = clr_q + ADR_W'(1);
            if (clr_q == ADR_W'(DEPTH - 1)) begin
               init_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!flush && op_valid) begin
               adr_d   = disp_adr;
               step_d  = STEP_W'(1);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (uop_ready) begin
               if (last_c) begin
                  if (op_valid) begin
                     adr_d  = disp_adr;
                     step_d = STEP_W'(1);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (step_q == STEP_W'(MAX_STEPS)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  adr_d  = tbl_rd;
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         clr_q       <= '0;
         adr_q       <= '0;
         step_q      <= '0;
         err_q       <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         adr_q       <= adr_d;
         step_q      <= step_d;
         err_q       <= err_d;
         init_done_q <= init_done_d;
      end
   end

endmodule

// File: tb/tb_micro_seq_ctrl.sv
// Directed bench for micro_seq_ctrl: vector table plus hand-written sequences.
module tb_micro_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       cfg_we;
   logic [8:0] cfg_adr;
   logic [8:0] cfg_data;
   logic       cfg_ready;
   logic       op_valid;
   logic       op_ready;
   logic [7:0] opcode;
   logic       uop_valid;
   logic       uop_ready;
   logic [8:0] uop_adr;
   logic       uop_last;
   logic       busy;
   logic       init_done;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   micro_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .cfg_we(cfg_we), .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
      .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
      .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_adr(uop_adr), .uop_last(uop_last),
      .busy(busy), .init_done(init_done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       flush;
      logic       op_valid;
      logic [7:0] opcode;
      logic       uop_ready;
      logic       exp_valid;
      logic [8:0] exp_adr;
      logic       exp_last;
      logic       exp_opr;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic fl, input logic ov, input logic [7:0] op, input logic ur,
                      input logic ev, input logic [8:0] ea, input logic el, input logic eo);
      vec_t v;
      v.flush = fl; v.op_valid = ov; v.opcode = op; v.uop_ready = ur;
      v.exp_valid = ev; v.exp_adr = ea; v.exp_last = el; v.exp_opr = eo;
      vq.push_back(v);
   endtask

   task automatic cfg_write(input logic [8:0] a, input logic [8:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_adr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic wait_init(input string name, output int cyc);
      cyc = 0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 5) chk({name, "_cfg_ready_init"}, 32'(cfg_ready), 32'd0);
         if (cyc == 10) cfg_we = 1'b0;
         if (init_done) break;
      end
   endtask

   initial begin
      int cyc;
      int beats;
      rst_n = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_adr = '0; cfg_data = '0;
      op_valid = 1'b0; opcode = '0; uop_ready = 1'b0;

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_uop_valid", 32'(uop_valid), 32'd0);
      chk("rst_op_ready", 32'(op_ready), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_uop_adr", 32'(uop_adr), 32'd0);

      // Release reset with a cfg write to entry 5 attempted during INIT
      cfg_we = 1'b1; cfg_adr = 9'h005; cfg_data = 9'h077;
      rst_n = 1'b1;
      wait_init("init", cyc);
      chk("init_cycles", 32'(cyc), 32'd512);
      chk("init_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("init_busy", 32'(busy), 32'd0);

      // Entry 5 must still hold the terminator
      @(negedge clk); op_valid = 1'b1; opcode = 8'h05; uop_ready = 1'b1;
      @(negedge clk); op_valid = 1'b0; #1;
      chk("init_we_adr", 32'(uop_adr), 32'h005);
      chk("init_we_last", 32'(uop_last), 32'd1);
      @(negedge clk);

      cfg_write(9'h059, 9'h100);
      cfg_write(9'h100, 9'h101);
      cfg_write(9'h101, 9'h000);
      cfg_write(9'h030, 9'h030);

      // fl ov op ur | valid adr last op_ready
      add(0, 1, 8'h59, 1, 0, 9'h000, 0, 1);   // straight walk
      add(0, 0, 8'h00, 1, 1, 9'h059, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h100, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h101, 1, 0);
      add(0, 0, 8'h00, 0, 0, 9'h000, 0, 1);
      add(0, 1, 8'h59, 1, 0, 9'h000, 0, 1);   // uop_ready 1,0,0,1,1
      add(0, 0, 8'h00, 1, 1, 9'h059, 0, 0);
      add(0, 0, 8'h00, 0, 1, 9'h100, 0, 0);
      add(0, 0, 8'h00, 0, 1, 9'h100, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h100, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h101, 1, 0);
      add(0, 0, 8'h00, 0, 0, 9'h000, 0, 1);
      add(0, 1, 8'h59, 1, 0, 9'h000, 0, 1);   // back-to-back dispatch
      add(0, 0, 8'h00, 1, 1, 9'h059, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h100, 0, 0);
      add(0, 1, 8'h0B, 1, 1, 9'h101, 1, 1);
      add(0, 0, 8'h00, 1, 1, 9'h00B, 1, 0);
      add(0, 0, 8'h00, 1, 0, 9'h000, 0, 1);
      add(0, 1, 8'h59, 1, 0, 9'h000, 0, 1);   // flush on second beat
      add(0, 0, 8'h00, 1, 1, 9'h059, 0, 0);
      add(1, 1, 8'h0B, 1, 1, 9'h100, 0, 0);
      add(0, 0, 8'h00, 1, 0, 9'h000, 0, 1);
      add(0, 0, 8'h00, 1, 0, 9'h000, 0, 1);
      add(0, 1, 8'h59, 1, 0, 9'h000, 0, 1);   // normal dispatch after flush
      add(0, 0, 8'h00, 1, 1, 9'h059, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h100, 0, 0);
      add(0, 0, 8'h00, 1, 1, 9'h101, 1, 0);
      add(0, 0, 8'h00, 1, 0, 9'h000, 0, 1);

      foreach (vq[i]) begin
         @(negedge clk);
         flush = vq[i].flush; op_valid = vq[i].op_valid;
         opcode = vq[i].opcode; uop_ready = vq[i].uop_ready;
         #1;
         chk($sformatf("v%0d_valid", i), 32'(uop_valid), 32'(vq[i].exp_valid));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].exp_valid));
         chk($sformatf("v%0d_last", i), 32'(uop_last), 32'(vq[i].exp_last));
         chk($sformatf("v%0d_op_ready", i), 32'(op_ready), 32'(vq[i].exp_opr));
         if (vq[i].exp_valid) chk($sformatf("v%0d_adr", i), 32'(uop_adr), 32'(vq[i].exp_adr));
         chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
      end
      @(negedge clk); flush = 1'b0; op_valid = 1'b0;

      // Runaway self-loop: exactly 64 beats, then sticky err
      @(negedge clk); op_valid = 1'b1; opcode = 8'h30; uop_ready = 1'b1;
      beats = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk); op_valid = 1'b0; #1;
         if (!uop_valid) break;
         beats++;
         if (uop_adr !== 9'h030 || uop_last !== 1'b0)
            chk("run_beat", 32'({uop_adr, uop_last}), 32'({9'h030, 1'b0}));
      end
      chk("run_beats", 32'(beats), 32'd64);
      chk("run_err", 32'(err), 32'd1);
      chk("run_busy", 32'(busy), 32'd0);

      @(negedge clk); op_valid = 1'b1; opcode = 8'h0B;
      @(negedge clk); op_valid = 1'b0; #1;
      chk("post_err_adr", 32'(uop_adr), 32'h00B);
      chk("post_err_last", 32'(uop_last), 32'd1);
      @(negedge clk); #1;
      chk("post_err_idle", 32'(uop_valid), 32'd0);
      chk("post_err_sticky", 32'(err), 32'd1);

      // Reset mid-sequence re-clears the whole table
      @(negedge clk); op_valid = 1'b1; opcode = 8'h59;
      @(negedge clk); op_valid = 1'b0; uop_ready = 1'b0; #1;
      chk("mid_valid", 32'(uop_valid), 32'd1);
      rst_n = 1'b0; #1;
      chk("mid_rst_valid", 32'(uop_valid), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      wait_init("reinit", cyc);
      chk("reinit_cycles", 32'(cyc), 32'd512);
      @(negedge clk); op_valid = 1'b1; opcode = 8'h59; uop_ready = 1'b1;
      @(negedge clk); op_valid = 1'b0; #1;
      chk("reinit_adr", 32'(uop_adr), 32'h059);
      chk("reinit_last", 32'(uop_last), 32'd1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
